// File: rtl/skullfet_pkg.sv
// skullfet_pkg: shared types and helpers for the SkullFET cell test sequencer.
//   state_t    - sequencer FSM states
//   cell_drv_t - drive bits for the inverter / NAND cell inputs
//   cell_out_t - observed or expected cell outputs
//   vec_drive  - drive pattern for vector index k
//   vec_expect - expected logic outputs for vector index k
package skullfet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int NUM_VEC    = 4;
  localparam int MIN_SETTLE = 3;

  typedef struct packed {
    logic inv_a;
    logic nand_a;
    logic nand_b;
  } cell_drv_t;

  typedef struct packed {
    logic inv_y;
    logic nand_y;
  } cell_out_t;

  // Vector k: the inverter and NAND B share k[0], NAND A takes k[1], so the
  // four vectors cover both inverter inputs and the full NAND truth table.
  function automatic cell_drv_t vec_drive(input logic [1:0] k);
    cell_drv_t d;
    d.inv_a  = k[0];
    d.nand_a = k[1];
    d.nand_b = k[0];
    return d;
  endfunction

  function automatic cell_out_t vec_expect(input logic [1:0] k);
    cell_out_t o;
    o.inv_y  = ~k[0];
    o.nand_y = ~(k[1] & k[0]);
    return o;
  endfunction

endpackage

// File: rtl/skullfet_test_seq_if.sv
// skullfet_test_seq_if: host control/status bits plus the cell drive and
// cell output nets of the SkullFET test sequencer.
//   slave  - the sequencer: takes start/stop/loop_en and cell outputs,
//            drives the cell inputs and all status.
//   master - host / cell side: the reverse direction.
interface skullfet_test_seq_if #(
  parameter int CNT_W = 16
);

  logic             start;
  logic             stop;
  logic             loop_en;
  logic             inv_a;
  logic             nand_a;
  logic             nand_b;
  logic             inv_y;
  logic             nand_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [1:0]       vec_idx;
  logic [1:0]       fail_vec;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] run_count;

  modport slave (
    input  start, stop, loop_en, inv_y, nand_y,
    output inv_a, nand_a, nand_b, busy, done, pass, fail,
           vec_idx, fail_vec, err_count, run_count
  );

  modport master (
    output start, stop, loop_en, inv_y, nand_y,
    input  inv_a, nand_a, nand_b, busy, done, pass, fail,
           vec_idx, fail_vec, err_count, run_count
  );

endinterface

// File: rtl/skullfet_sync2.sv
// skullfet_sync2: two-flop synchronizer for one asynchronous cell output.
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, both flops clear to 0
//   d     - asynchronous input
//   q     - synchronized output, two edges behind d
module skullfet_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/skullfet_test_seq.sv
// skullfet_test_seq: walks the four SkullFET input vectors, holds each for
// SETTLE_CYCLES, samples the synchronized cell outputs and tallies errors.
//   clk   - single clock
//   rst_n - asynchronous active-low reset
//   bus   - control (start/stop/loop_en), cell drives (inv_a/nand_a/nand_b),
//           cell outputs (inv_y/nand_y), status (busy/done/pass/fail,
//           vec_idx/fail_vec, err_count/run_count)
module skullfet_test_seq
  import skullfet_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input logic               clk,
  input logic               rst_n,
  skullfet_test_seq_if.slave bus
);

  if (SETTLE_CYCLES < MIN_SETTLE || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("skullfet_test_seq: SETTLE_CYCLES must be in 3..255");
  end

  localparam logic [7:0]       SETTLE_LD = 8'(SETTLE_CYCLES);
  localparam logic [1:0]       LAST_VEC  = 2'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       vec_idx_q, vec_idx_d;
  logic [1:0]       fail_vec_q, fail_vec_d;
  logic             start_q, start_d;
  logic             fail_q, fail_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  cell_drv_t        drv_q, drv_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] run_count_q, run_count_d;

  logic      inv_y_s;
  logic      nand_y_s;
  cell_out_t obs;
  cell_out_t exp_out;
  logic      mismatch;

  skullfet_sync2 u_sync_inv  (.clk(clk), .rst_n(rst_n), .d(bus.inv_y),  .q(inv_y_s));
  skullfet_sync2 u_sync_nand (.clk(clk), .rst_n(rst_n), .d(bus.nand_y), .q(nand_y_s));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_idx_d   = vec_idx_q;
    fail_vec_d  = fail_vec_q;
    fail_d      = fail_q;
    err_count_d = err_count_q;
    run_count_d = run_count_q;
    drv_d       = drv_q;
    // The host start level is registered once; a same-cycle stop vetoes it
    // so a start+stop pair can never launch a run one edge later.
    start_d     = bus.start & ~bus.stop;

    obs.inv_y  = inv_y_s;
    obs.nand_y = nand_y_s;
    exp_out    = vec_expect(vec_idx_q);
    mismatch   = (obs != exp_out);

    case (state_q)
      IDLE, DONE: begin
        if (bus.stop) begin
          state_d = IDLE;
          drv_d   = '0;
        end else if (start_q) begin
          state_d     = APPLY;
          vec_idx_d   = '0;
          fail_vec_d  = '0;
          fail_d      = 1'b0;
          err_count_d = '0;
          run_count_d = '0;
          drv_d       = vec_drive(2'd0);
        end
      end
      APPLY: begin
        if (bus.stop) begin
          state_d = IDLE;
          drv_d   = '0;
        end else begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end
      end
      SETTLE: begin
        if (bus.stop) begin
          state_d = IDLE;
          drv_d   = '0;
        end else if (cnt_q == 8'd1) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SAMPLE: begin
        if (bus.stop) begin
          state_d = IDLE;
          drv_d   = '0;
        end else begin
          if (mismatch) begin
            fail_d     = 1'b1;
            fail_vec_d = vec_idx_q;
            if (err_count_q != {CNT_W{1'b1}}) begin
              err_count_d = err_count_q + CNT_ONE;
            end
          end
          if (vec_idx_q != LAST_VEC) begin
            vec_idx_d = vec_idx_q + 2'd1;
            drv_d     = vec_drive(vec_idx_q + 2'd1);
            state_d   = APPLY;
          end else begin
            run_count_d = run_count_q + CNT_ONE;
            if (bus.loop_en) begin
              vec_idx_d = '0;
              drv_d     = vec_drive(2'd0);
              state_d   = APPLY;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        drv_d   = '0;
      end
    endcase

    // Status flags are decoded from the next state so they line up with
    // state_q and can never overlap.
    busy_d = (state_d == APPLY) || (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vec_idx_q   <= '0;
      fail_vec_q  <= '0;
      start_q     <= 1'b0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drv_q       <= '0;
      err_count_q <= '0;
      run_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_idx_q   <= vec_idx_d;
      fail_vec_q  <= fail_vec_d;
      start_q     <= start_d;
      fail_q      <= fail_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      drv_q       <= drv_d;
      err_count_q <= err_count_d;
      run_count_q <= run_count_d;
    end
  end

  assign bus.inv_a     = drv_q.inv_a;
  assign bus.nand_a    = drv_q.nand_a;
  assign bus.nand_b    = drv_q.nand_b;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.pass      = done_q & ~fail_q;
  assign bus.vec_idx   = vec_idx_q;
  assign bus.fail_vec  = fail_vec_q;
  assign bus.err_count = err_count_q;
  assign bus.run_count = run_count_q;

endmodule

// File: tb/tb_skullfet_test_seq.sv
// tb_skullfet_test_seq: three sequencer instances with behavioural cells.
//   dut_a: SETTLE_CYCLES=4, zero-delay cells with selectable stuck-at faults
//   dut_b: SETTLE_CYCLES=3, inverter settling a selectable number of cycles
//   dut_c: SETTLE_CYCLES=4, CNT_W=2, NAND stuck at 1, looping runs
module tb_skullfet_test_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  skullfet_test_seq_if #(.CNT_W(16)) ifa ();
  skullfet_test_seq_if #(.CNT_W(16)) ifb ();
  skullfet_test_seq_if #(.CNT_W(2))  ifc ();

  skullfet_test_seq #(.SETTLE_CYCLES(4), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  skullfet_test_seq #(.SETTLE_CYCLES(3), .CNT_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  skullfet_test_seq #(.SETTLE_CYCLES(4), .CNT_W(2))  dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  logic [2:0] start_v = '0;
  logic [2:0] stop_v  = '0;
  logic [2:0] loop_v  = '0;
  logic [2:0] done_v;

  assign ifa.start = start_v[0];  assign ifa.stop = stop_v[0];  assign ifa.loop_en = loop_v[0];
  assign ifb.start = start_v[1];  assign ifb.stop = stop_v[1];  assign ifb.loop_en = loop_v[1];
  assign ifc.start = start_v[2];  assign ifc.stop = stop_v[2];  assign ifc.loop_en = loop_v[2];
  assign done_v = {ifc.done, ifb.done, ifa.done};

  // dut_a cells: 0 good, 1 nand stuck1, 2 inv stuck0, 3 nand stuck0, 4 inv stuck1
  logic [2:0] fault_a = 3'd0;
  assign ifa.inv_y  = (fault_a == 3'd2) ? 1'b0 : (fault_a == 3'd4) ? 1'b1 : ~ifa.inv_a;
  assign ifa.nand_y = (fault_a == 3'd1) ? 1'b1 : (fault_a == 3'd3) ? 1'b0 : ~(ifa.nand_a & ifa.nand_b);

  // dut_b inverter: tap t gives an output that settles before edge e+t+2,
  // i.e. a cell delay of d = t+2 cycles from drive edge e.
  logic [7:0] inv_hist = 8'hFF;
  logic [2:0] tap_b = 3'd1;
  always @(posedge clk) inv_hist <= {inv_hist[6:0], ~ifb.inv_a};
  assign ifb.inv_y  = inv_hist[tap_b];
  assign ifb.nand_y = ~(ifb.nand_a & ifb.nand_b);

  assign ifc.inv_y  = ~ifc.inv_a;
  assign ifc.nand_y = 1'b1;

  int n_checks = 0;
  int n_err    = 0;

  // {inv_a, nand_a, nand_b} loaded for vectors 0..3
  logic [2:0] exp_drv [4] = '{3'b000, 3'b101, 3'b010, 3'b111};

  typedef struct {
    logic [2:0]  fault;
    logic [15:0] exp_err;
    logic [1:0]  exp_fv;
    logic        exp_pass;
  } scen_t;
  scen_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Pulse start for one edge (edge 0) and count edges until done rises.
  task automatic run_sel(input int sel, output int edges);
    edges = 0;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (sel == 0 && i <= 19 && (i - 1) % 6 == 0) begin
        chk("apply_drv", {ifa.inv_a, ifa.nand_a, ifa.nand_b}, exp_drv[(i - 1) / 6]);
        chk("apply_idx", ifa.vec_idx, (i - 1) / 6);
      end
      if (done_v[sel]) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic chk_reset_a(input string name);
    chk(name, {ifa.busy, ifa.done, ifa.fail, ifa.pass, ifa.inv_a, ifa.nand_a, ifa.nand_b,
               ifa.vec_idx, ifa.fail_vec}, 0);
    chk({name, "_err"}, ifa.err_count, 0);
    chk({name, "_run"}, ifa.run_count, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;

    tbl[0] = '{fault: 3'd0, exp_err: 16'd0, exp_fv: 2'd0, exp_pass: 1'b1};
    tbl[1] = '{fault: 3'd1, exp_err: 16'd1, exp_fv: 2'd3, exp_pass: 1'b0};
    tbl[2] = '{fault: 3'd2, exp_err: 16'd2, exp_fv: 2'd2, exp_pass: 1'b0};
    tbl[3] = '{fault: 3'd3, exp_err: 16'd3, exp_fv: 2'd2, exp_pass: 1'b0};
    tbl[4] = '{fault: 3'd4, exp_err: 16'd2, exp_fv: 2'd3, exp_pass: 1'b0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_a("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Scenario table on dut_a; each run restarts from DONE and must clear.
    for (int s = 0; s < 5; s++) begin
      fault_a = tbl[s].fault;
      run_sel(0, edges);
      $display("run a[%0d]: edges=%0d err_count=%0d fail_vec=%0d pass=%0b run_count=%0d",
               s, edges, ifa.err_count, ifa.fail_vec, ifa.pass, ifa.run_count);
      chk("done_edge", edges, 25);
      chk("err_count", ifa.err_count, tbl[s].exp_err);
      chk("fail_vec", ifa.fail_vec, tbl[s].exp_fv);
      chk("pass", ifa.pass, tbl[s].exp_pass);
      chk("fail", ifa.fail, !tbl[s].exp_pass);
      chk("run_count", ifa.run_count, 1);
      chk("busy_in_done", ifa.busy, 0);
      chk("held_drv", {ifa.inv_a, ifa.nand_a, ifa.nand_b}, 3'b111);
    end

    // stop during SETTLE of vector 2 (NAND stuck at 0: vectors 0,1 fail)
    fault_a = 3'd3;
    start_v[0] = 1'b1; @(posedge clk); #1; start_v[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("pre_stop_busy", ifa.busy, 1);
    chk("pre_stop_idx", ifa.vec_idx, 2);
    chk("pre_stop_err", ifa.err_count, 2);
    stop_v[0] = 1'b1;
    @(posedge clk); #1;
    stop_v[0] = 1'b0;
    $display("stop a: busy=%0b done=%0b err_count=%0d fail_vec=%0d", ifa.busy, ifa.done,
             ifa.err_count, ifa.fail_vec);
    chk("stop_flags", {ifa.busy, ifa.done, ifa.pass, ifa.inv_a, ifa.nand_a, ifa.nand_b}, 0);
    chk("stop_err_held", ifa.err_count, 2);
    chk("stop_fail_held", {ifa.fail, ifa.fail_vec}, 3'b101);
    @(posedge clk); #1;
    chk("stop_stays_idle", ifa.busy, 0);

    // start+stop together during SETTLE of vector 2: stop wins, no relaunch
    start_v[0] = 1'b1; @(posedge clk); #1; start_v[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("pre_ss_busy", ifa.busy, 1);
    start_v[0] = 1'b1;
    stop_v[0]  = 1'b1;
    @(posedge clk); #1;
    $display("start+stop a: busy=%0b done=%0b err_count=%0d", ifa.busy, ifa.done, ifa.err_count);
    chk("ss_flags", {ifa.busy, ifa.done, ifa.inv_a, ifa.nand_a, ifa.nand_b}, 0);
    chk("ss_err_held", ifa.err_count, 2);
    @(posedge clk); #1;
    chk("ss_hold_idle", ifa.busy, 0);
    start_v[0] = 1'b0;
    stop_v[0]  = 1'b0;
    @(posedge clk); #1;
    chk("ss_no_relaunch", ifa.busy, 0);

    // async reset during SAMPLE of vector 1 (inverter stuck at 0: vector 0 fails)
    fault_a = 3'd2;
    start_v[0] = 1'b1; @(posedge clk); #1; start_v[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("pre_rst_busy", ifa.busy, 1);
    chk("pre_rst_err", ifa.err_count, 1);
    #2 rst_n = 1'b0;
    #1;
    $display("reset a: busy=%0b err_count=%0d vec_idx=%0d", ifa.busy, ifa.err_count, ifa.vec_idx);
    chk_reset_a("async_reset");
    @(negedge clk) rst_n = 1'b1;
    fault_a = 3'd0;
    @(negedge clk);
    run_sel(0, edges);
    $display("run a after reset: edges=%0d err_count=%0d pass=%0b", edges, ifa.err_count, ifa.pass);
    chk("post_rst_edge", edges, 25);
    chk("post_rst_pass", ifa.pass, 1);
    chk("post_rst_err", ifa.err_count, 0);

    // dut_b: 3-cycle inverter delay is within SETTLE_CYCLES=3
    tap_b = 3'd1;
    run_sel(1, edges);
    $display("run b d=3: edges=%0d err_count=%0d fail_vec=%0d pass=%0b", edges, ifb.err_count,
             ifb.fail_vec, ifb.pass);
    chk("b3_edge", edges, 21);
    chk("b3_pass", ifb.pass, 1);
    chk("b3_err", ifb.err_count, 0);
    stop_v[1] = 1'b1; @(posedge clk); #1; stop_v[1] = 1'b0;
    chk("b_idle_drv", {ifb.done, ifb.inv_a, ifb.nand_a, ifb.nand_b}, 0);
    repeat (10) @(posedge clk);
    // 4-cycle delay: every inverter transition (vectors 1..3) is caught late
    tap_b = 3'd2;
    @(negedge clk);
    run_sel(1, edges);
    $display("run b d=4: edges=%0d err_count=%0d fail_vec=%0d pass=%0b", edges, ifb.err_count,
             ifb.fail_vec, ifb.pass);
    chk("b4_edge", edges, 21);
    chk("b4_err", ifb.err_count, 3);
    chk("b4_fail_vec", ifb.fail_vec, 3);
    chk("b4_pass", ifb.pass, 0);

    // dut_c: 2-bit counters, looping; 5 passes total, loop dropped in pass 5
    loop_v[2] = 1'b1;
    start_v[2] = 1'b1; @(posedge clk); #1; start_v[2] = 1'b0;
    edges = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (i == 49) begin
        chk("c_run_2", ifc.run_count, 2);
        chk("c_err_2", ifc.err_count, 2);
      end
      if (i == 100) begin
        chk("c_busy_p5", ifc.busy, 1);
        chk("c_run_wrap", ifc.run_count, 0);
        chk("c_err_sat", ifc.err_count, 3);
        loop_v[2] = 1'b0;
      end
      if (ifc.done) begin
        edges = i;
        break;
      end
    end
    $display("run c loop: edges=%0d err_count=%0d run_count=%0d fail_vec=%0d pass=%0b", edges,
             ifc.err_count, ifc.run_count, ifc.fail_vec, ifc.pass);
    chk("c_done_edge", edges, 121);
    chk("c_err_final", ifc.err_count, 3);
    chk("c_run_final", ifc.run_count, 1);
    chk("c_done_pass", {ifc.done, ifc.pass, ifc.busy}, 3'b100);
    chk("c_fail_vec", ifc.fail_vec, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/skullfet_test_seq.md
# skullfet_test_seq

Sequencer that exercises the SkullFET standard cells (`skullfet_inverter`, `skullfet_nand`) with an exhaustive input-vector set. It drives the cell inputs from registers and waits a programmable settle time. It then samples the cell outputs through a 2-flop synchronizer, checks them against expected logic values and reports errors. It sits between the host/logic-analyser control bits and the custom-cell macros, and is the only driver of the cell inputs.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4. Cycles held between applying a vector and sampling it. Legal range 3..255; values below 3 are a configuration error.
- `CNT_W`, default 16. Width of `err_count` and `run_count`.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level, sampled each edge; starts a run from IDLE or DONE.
- `stop`  in  1  level; aborts a run in progress.
- `loop_en`  in  1  when high at the end of vector 3, the block restarts at vector 0 instead of finishing.
- `inv_a`  out  1  registered drive to inverter A.
- `nand_a`, `nand_b`  out  1 each  registered drives to NAND A/B.
- `inv_y`, `nand_y`  in  1 each  asynchronous cell outputs.
- `busy`  out  1  high in APPLY/SETTLE/SAMPLE.
- `done`  out  1  high in DONE.
- `pass`  out  1  `done & ~fail`, combinational.
- `fail`  out  1  sticky; set on any mismatch in the current run.
- `vec_idx`  out  2  current vector index.
- `fail_vec`  out  2  index of the most recent mismatching vector.
- `err_count`  out  CNT_W  mismatches in the current run; saturates at all-ones.
- `run_count`  out  CNT_W  completed 4-vector passes in the current run; wraps.

## Operation
- Reset values: state IDLE; all drives 0; `busy`/`done`/`fail` 0; `vec_idx`, `fail_vec`, `err_count`, `run_count` 0; synchronizer flops 0.
- Vector k (0..3) is applied as follows:
  - Drives: `inv_a = k[0]`, `nand_a = k[1]`, `nand_b = k[0]`.
  - Expected outputs: `inv_y = ~k[0]`, `nand_y = ~(k[1] & k[0])`.
- FSM states:
  - IDLE: if `start & ~stop`, go to APPLY; on that edge clear `err_count`, `run_count`, `fail`, `fail_vec` and set `vec_idx` = 0.
  - APPLY (1 cycle): the drive registers hold vector `vec_idx`; they are loaded on the edge entering APPLY. Next state is SETTLE.
  - SETTLE (`SETTLE_CYCLES` cycles, 8-bit down-counter): then go to SAMPLE.
  - SAMPLE (1 cycle): compare the synchronized outputs with the expected values.
    - On mismatch: `err_count`+1 (saturating), `fail_vec` <= `vec_idx`, `fail` <= 1.
    - If `vec_idx` < 3: increment `vec_idx`, go to APPLY.
    - Else: `run_count`+1. If `loop_en`, set `vec_idx` = 0 and go to APPLY; otherwise go to DONE.
  - DONE: drives and results are held. `start & ~stop` restarts exactly as from IDLE; `stop` goes to IDLE.
- `stop` in any busy state goes to IDLE on the next edge. Drives go to 0; counters, `fail` and `fail_vec` are held; `done` stays 0.
- If `start` and `stop` are both high, `stop` wins.
- Asserting `rst_n` low mid-run forces all reset values immediately, without waiting for a clock edge.

## Timing
- Per-vector cost is `SETTLE_CYCLES` + 2 cycles. With `start` sampled at edge 0 and `loop_en`=0, `done` rises at edge 4·(`SETTLE_CYCLES`+2)+1.
- Synchronizer latency is 2 edges. A cell whose output settles d cycles after the drive edge is checked correctly iff d ≤ `SETTLE_CYCLES`.
- `busy` and `done` are registered state decodes; they are never high together.

## Structure
- Package `skullfet_pkg`: state enum (IDLE, APPLY, SETTLE, SAMPLE, DONE), `NUM_VEC` = 4, an expected-output function of the vector index, and a minimum-settle constant of 3.
- Sub-module `skullfet_sync2`: 2-flop synchronizer with asynchronous active-low reset. It is instantiated once per cell output.
- Parameter check: elaboration fails if `SETTLE_CYCLES` < 3.

## Test plan
- Zero-delay behavioural cells, `SETTLE_CYCLES`=4, one `start` pulse → `done` at edge 25; `pass`=1, `err_count`=0, `run_count`=1.
- `nand_y` stuck at 1 → `err_count`=1, `fail_vec`=3, `pass`=0.
- `SETTLE_CYCLES`=3 with a 3-cycle inverter delay → `pass`=1. The same bench with a 4-cycle delay → `err_count`=3 (vectors 1..3), `fail_vec`=3.
- `CNT_W`=2, `nand_y` stuck at 1, `loop_en`=1 for 5 passes then dropped → `err_count`=3 (saturated), `run_count`=1 (wrapped), `done`=1.
- `stop` (or `start`+`stop`) in SETTLE of vector 2 → next edge IDLE; `busy`=0, `done`=0, drives 0, `err_count` held.
- `rst_n` low during SAMPLE → all outputs at reset values before the next `clk` edge; a new `start` afterwards runs clean.
